// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DIV_WIDTH = 4;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  localparam logic DBZ_FILL = 1'b1;
endpackage

// File: rtl/trial_subtractor.sv
// trial_subtractor: N-bit unsigned a-b with borrow out (a < b)
module trial_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = (CNT_W > $clog2(WIDTH)) ? CNT_W : $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic [WIDTH:0] shifted, diff;
  logic borrow;
  // r_q's top bit is kept as the extra bit so divisors with the MSB set compare correctly
  assign shifted = {r_q, q_q[WIDTH-1]};
  trial_subtractor #(.N(WIDTH+1)) u_sub (
    .a(shifted),
    .b({1'b0, d_q}),
    .diff(diff),
    .borrow(borrow)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    r_d = r_q;
    d_d = d_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (state_q == IDLE && start) begin
      if (divisor == '0) begin
        state_d = DONE;
        quo_d = {WIDTH{DBZ_FILL}};
        rem_d = dividend;
        dbz_d = 1'b1;
      end else begin
        state_d = RUN;
        q_d = dividend;
        r_d = '0;
        d_d = divisor;
        cnt_d = CW'(WIDTH-1);
      end
    end else if (state_q == RUN) begin
      // diff's top bit is always 0 when there is no borrow; folding it in keeps every bit live
      q_d = {q_q[WIDTH-2:0], ~(borrow | diff[WIDTH])};
      r_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        quo_d = q_d;
        rem_d = r_d;
        dbz_d = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: randomized and directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [3:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int accepted = 0;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input string tag);
    int lat, bcnt;
    int exp_q, exp_r, exp_lat, exp_busy;
    logic exp_z;
    exp_z = (b == 0);
    exp_q = exp_z ? 15 : int'(a) / int'(b);
    exp_r = exp_z ? int'(a) : int'(a) % int'(b);
    exp_lat = exp_z ? 0 : 4;
    exp_busy = exp_z ? 0 : 4;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    accepted++;
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s latency %0d/%0d got %0d want %0d", tag, a, b, lat, exp_lat); end
    checks++;
    if (bcnt !== exp_busy) begin errors++; $display("FAIL %s busy_cycles %0d/%0d got %0d want %0d", tag, a, b, bcnt, exp_busy); end
    checks++;
    if (int'(quotient) !== exp_q || int'(remainder) !== exp_r || div_by_zero !== exp_z) begin
      errors++;
      $display("FAIL %s result %0d/%0d got q=%0d r=%0d z=%0b want q=%0d r=%0d z=%0b", tag, a, b, quotient, remainder, div_by_zero, exp_q, exp_r, exp_z);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s done_pulse got done=%0b busy=%0b want 0 0", tag, done, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 11'b0) begin
      errors++;
      $display("FAIL reset got q=%0d r=%0d b=%0b d=%0b z=%0b want all 0", quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_div(4'd13, 4'd3, "basic_13_3");
    run_div(4'd15, 4'd1, "div_by_one");
    run_div(4'd5, 4'd7, "small_dividend");
    run_div(4'd15, 4'd15, "equal");
    run_div(4'd14, 4'd9, "msb_divisor");
  endtask

  task automatic test_div_zero;
    run_div(4'd9, 4'd0, "div_zero");
    run_div(4'd8, 4'd2, "after_zero");
    run_div(4'd9, 4'd0, "div_zero_again");
  endtask

  task automatic test_ignore_start;
    int d0, n;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(posedge clk); #1;
    dividend = 4'd7; divisor = 4'd7;
    n = 0;
    while (!done && n < 20) begin
      dividend = 4'($urandom); divisor = 4'($urandom_range(15, 1));
      @(posedge clk); #1;
      n++;
    end
    dividend = 4'd3; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 4'd2 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start result got q=%0d r=%0d want q=2 r=2", quotient, remainder);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_start done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_mid_reset;
    int d0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset got q=%0d r=%0d b=%0b d=%0b z=%0b want all 0", quotient, remainder, busy, done, div_by_zero);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset no_done got %0d pulses busy=%0b want 0 0", done_cnt - d0, busy); end
    run_div(4'd10, 4'd4, "after_reset");
  endtask

  task automatic test_sweep;
    int d0, a0;
    d0 = done_cnt;
    a0 = accepted;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_div(4'(a), 4'(b), "sweep");
    checks++;
    if (done_cnt - d0 !== accepted - a0) begin errors++; $display("FAIL sweep done_count got %0d want %0d", done_cnt - d0, accepted - a0); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_div(4'($urandom), 4'($urandom), "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_mid_reset();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider: one trial subtraction per clock, one quotient bit per clock.
- Provides the inverse arithmetic of the team's combinational 4-bit adders: repeated subtraction instead of addition, iterated over time rather than rippled through gates.
- Sits beside the adder blocks as the first clocked arithmetic unit.
- Handshake is start/busy/done, so a controller or testbench can drive back-to-back divisions.

Parameters:
- WIDTH, 4, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, sampled with accepted start
- divisor  input  WIDTH  unsigned divisor, sampled with accepted start
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- busy  output  1  high while a division is in progress (RUN state)
- done  output  1  one-cycle pulse: results valid and updated
- div_by_zero  output  1  flag for the most recent completed division

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at an edge, any state, including mid-division):
  - state -> IDLE.
  - quotient, remainder, busy, done, div_by_zero all -> 0.
  - In-flight operation discarded, no done pulse.
  - rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0 at edge k -> RUN. Working registers loaded: Q=dividend, R=0, count=WIDTH-1.
  - start=1 and divisor==0 -> DONE directly.
  - start=0 -> stay in IDLE.
- RUN, one iteration per edge:
  - shifted = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - trial = shifted - divisor_reg, computed WIDTH+1 bits wide (borrow out).
  - No borrow: R=trial[WIDTH-1:0] and new Q LSB=1.
  - Borrow: R=shifted and new Q LSB=0.
  - Q shifts left each iteration.
  - After WIDTH iterations (edge k+WIDTH) -> DONE.
- Carry-out rule: the shift must keep the carried-out bit of R. Compare {R_msb, shifted} against divisor so that WIDTH-bit divisors >= 2^(WIDTH-1) are correct.
- DONE (one cycle):
  - done=1, busy=0.
  - quotient/remainder registers hold the final Q/R. They are loaded on the edge entering DONE.
  - Next edge -> IDLE unconditionally. Start during DONE is ignored.
- Divide by zero:
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - Latency 1 cycle (done high the cycle after start is accepted).
  - Any normal completion clears div_by_zero.
- busy:
  - 1 exactly in RUN, i.e. cycles k+1..k+WIDTH after start accepted at edge k.
- Latency:
  - Normal division: done high WIDTH+1 cycles after the cycle start was sampled. For WIDTH=4, start sampled at edge k, done visible after edge k+WIDTH.
  - Throughput: one division per WIDTH+2 cycles.
- Start while busy or in DONE: ignored, and operands are not re-sampled.
- Operand capture: divisor is captured at start. Input changes during RUN have no effect.
- Result hold: quotient/remainder/div_by_zero keep their value from done until the next done or reset. They never show intermediate values.
- Invariant on every normal completion: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package div_pkg:
  - state enum (IDLE, RUN, DONE).
  - localparam for counter width $clog2(WIDTH).
  - constant for the div-by-zero quotient pattern (all ones).
- Sub-module trial_subtractor (WIDTH+1 bits):
  - Inputs a, b. Outputs diff and borrow.
  - Purely combinational, instantiated once per divider.
  - Reusable later in an adder/subtractor comparison.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse at edge k -> busy high for 4 cycles; done at edge k+4 with quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=5, divisor=7 -> quotient=0, remainder=5. Then dividend=15, divisor=15 -> quotient=1, remainder=0. Then dividend=14, divisor=9 (MSB-set divisor) -> quotient=1, remainder=5.
- dividend=9, divisor=0 -> done after 1 cycle, quotient=15, remainder=9, div_by_zero=1, busy never high. A following 8/2 gives 4/0 and clears div_by_zero.
- Start 12/5 (expected 2/2), reassert start with 7/7 and change the inputs during RUN and during the DONE cycle -> result still 2/2, single done pulse, second start ignored.
- Start 13/3 (expected 4/1 if uninterrupted), assert rst at RUN cycle 2 -> next cycle all outputs 0 and state IDLE, no done. A subsequent 10/4 returns 2/2.
- Exhaustive sweep of all 256 operand pairs, including 0/0, back-to-back -> every result matches the reference model (x/0 rule applied), and done counts equal start-accepted counts.
